ram_dp_arbiter: RTL and testbench

- Shares one dual-port RAM (port A read, port B write, active-low chip enables) between NumReq read requesters and NumReq write requesters using round-robin arbitration.
- Suppresses same-cycle read/write address collisions; the RAM flags these as errors.
- Returns read data tagged with the requester ID and sits between the memory and the engine's consumers.

---
 rtl/ram_dp_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ram_dp_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter
//   Shares one dual-port RAM (port A read, port B write, active-low enables)
//   between NumReq read requesters and NumReq write requesters. Each side has
//   its own round-robin arbiter. Read responses come back tagged with the
//   requester index after the RAM's read latency (1 + Pipelined cycles).
//
// Ports
//   clk, rst             clock (also RAM clkA/clkB), asynchronous active-high reset
//   rd_req/rd_addr       per-requester read request and address slices
//   rd_gnt               one-hot read grant (combinational)
//   wr_req/wr_addr/wr_data  per-requester write request, address, data slices
//   wr_gnt               one-hot write grant (combinational)
//   rd_valid/rd_id/rd_data  tagged read response; rd_data is 0 when not valid
//   ram_cenA/ram_aA      RAM read port enable (active-low) and address
//   ram_cenB/ram_aB/ram_d/ram_bw  RAM write port enable, address, data, bit mask
//   ram_q                RAM read data
module ram_dp_arbiter #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8,
  parameter int Pipelined = 0,
  localparam int IdWidth  = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             rd_req,
  input  logic [NumReq*AddrWidth-1:0]   rd_addr,
  output logic [NumReq-1:0]             rd_gnt,
  input  logic [NumReq-1:0]             wr_req,
  input  logic [NumReq*AddrWidth-1:0]   wr_addr,
  input  logic [NumReq*DataWidth-1:0]   wr_data,
  output logic [NumReq-1:0]             wr_gnt,
  output logic                          rd_valid,
  output logic [IdWidth-1:0]            rd_id,
  output logic [DataWidth-1:0]          rd_data,
  output logic                          ram_cenA,
  output logic [AddrWidth-1:0]          ram_aA,
  output logic                          ram_cenB,
  output logic [AddrWidth-1:0]          ram_aB,
  output logic [DataWidth-1:0]          ram_d,
  output logic [DataWidth-1:0]          ram_bw,
  input  logic [DataWidth-1:0]          ram_q
);

  // Response pipeline depth equals the RAM read latency.
  localparam int Depth = 1 + Pipelined;
  localparam logic [IdWidth-1:0] LastId = IdWidth'(NumReq - 1);

  // ---------------------------------------------------------------------------
  // Unpack the flat per-requester buses.
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0] rd_addr_arr [NumReq];
  logic [AddrWidth-1:0] wr_addr_arr [NumReq];
  logic [DataWidth-1:0] wr_data_arr [NumReq];

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign rd_addr_arr[gi] = rd_addr[gi*AddrWidth +: AddrWidth];
      assign wr_addr_arr[gi] = wr_addr[gi*AddrWidth +: AddrWidth];
      assign wr_data_arr[gi] = wr_data[gi*DataWidth +: DataWidth];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick: first asserted request at or above ptr, wrapping at
  // NumReq. Returns {found, index}. Walking the offsets from high to low lets
  // the closest-to-pointer requester overwrite any farther one.
  // ---------------------------------------------------------------------------
  function automatic logic [IdWidth:0] rr_pick(input logic [NumReq-1:0]  req,
                                               input logic [IdWidth-1:0] ptr);
    logic [IdWidth:0] pick;
    int               idx;
    pick = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (req[idx]) begin
        pick = {1'b1, idx[IdWidth-1:0]};
      end
    end
    return pick;
  endfunction

  // Pointer advance wraps at NumReq, so ids >= NumReq never appear even when
  // NumReq is not a power of two.
  function automatic logic [IdWidth-1:0] ptr_after(input logic [IdWidth-1:0] win);
    return (win == LastId) ? '0 : win + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IdWidth-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [IdWidth-1:0]   wr_ptr_reg, wr_ptr_next;
  logic                 rd_any, wr_any;
  logic [IdWidth-1:0]   rd_win, wr_win;
  logic [AddrWidth-1:0] rd_win_addr, wr_win_addr;
  logic [DataWidth-1:0] wr_win_data;
  logic                 addr_collision;
  logic                 rd_fire, wr_fire;

  assign {rd_any, rd_win} = rr_pick(rd_req, rd_ptr_reg);
  assign {wr_any, wr_win} = rr_pick(wr_req, wr_ptr_reg);

  assign rd_win_addr = rd_addr_arr[rd_win];
  assign wr_win_addr = wr_addr_arr[wr_win];
  assign wr_win_data = wr_data_arr[wr_win];

  // Same-address read and write in one cycle is an error at the RAM. The
  // write wins; the read stays pending and, retrying next cycle, observes
  // the freshly written word.
  assign addr_collision = rd_any && wr_any && (rd_win_addr == wr_win_addr);

  // Reset also masks the combinational grants so nothing reaches the RAM
  // while the pointers are being cleared.
  assign rd_fire = rd_any && !addr_collision && !rst;
  assign wr_fire = wr_any && !rst;

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
      assign rd_gnt[gi] = rd_fire && (rd_win == IdWidth'(gi));
      assign wr_gnt[gi] = wr_fire && (wr_win == IdWidth'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // RAM interface. Idle address/data are forced to zero.
  // ---------------------------------------------------------------------------
  assign ram_cenA = !rd_fire;
  assign ram_aA   = rd_fire ? rd_win_addr : '0;
  assign ram_cenB = !wr_fire;
  assign ram_aB   = wr_fire ? wr_win_addr : '0;
  assign ram_d    = wr_fire ? wr_win_data : '0;
  assign ram_bw   = '1;

  // ---------------------------------------------------------------------------
  // Pointer registers: move past the winner on a grant, hold otherwise.
  // A stalled read (collision) leaves rd_ptr untouched so the same requester
  // wins the retry.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (rd_fire) begin
      rd_ptr_next = ptr_after(rd_win);
    end
    if (wr_fire) begin
      wr_ptr_next = ptr_after(wr_win);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: {valid, id} travels alongside the RAM's read latency.
  // The id is zeroed for empty slots so rd_id rests at 0 between responses.
  // ---------------------------------------------------------------------------
  logic               pipe_valid_reg [Depth];
  logic [IdWidth-1:0] pipe_id_reg    [Depth];

  generate
    for (genvar gi = 0; gi < Depth; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_id_reg[gi]    <= '0;
          end else begin
            pipe_valid_reg[gi] <= rd_fire;
            pipe_id_reg[gi]    <= rd_fire ? rd_win : '0;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_id_reg[gi]    <= '0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_id_reg[gi]    <= pipe_id_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rd_valid = pipe_valid_reg[Depth-1];
  assign rd_id    = pipe_id_reg[Depth-1];
  // ram_q holds stale data between reads; present zeros unless a response
  // is actually being delivered.
  assign rd_data  = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter. Two instances (Pipelined=0 and Pipelined=1) see
// the same requests, each attached to its own behavioural RAM. Expected
// responses go into a per-instance queue when a read is expected to be
// granted and are popped when the instance raises rd_valid.
module tb_ram_dp_arbiter;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_req, wr_req;
  logic [NR*AW-1:0]  rd_addr, wr_addr;
  logic [NR*DW-1:0]  wr_data;

  logic [NR-1:0] rd_gnt_w   [2];
  logic [NR-1:0] wr_gnt_w   [2];
  logic          rd_valid_w [2];
  logic [IW-1:0] rd_id_w    [2];
  logic [DW-1:0] rd_data_w  [2];
  logic          cena_w     [2];
  logic          cenb_w     [2];
  logic [AW-1:0] aa_w       [2];
  logic [AW-1:0] ab_w       [2];
  logic [DW-1:0] d_w        [2];
  logic [DW-1:0] bw_w       [2];
  logic [DW-1:0] q_w        [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q [2][$];
  logic [DW-1:0] ref_mem [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Two DUTs with their RAM models and response monitors
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ram_dp_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .Pipelined(gi)
      ) u_dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_w[gi]),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_w[gi]),
        .rd_valid(rd_valid_w[gi]), .rd_id(rd_id_w[gi]), .rd_data(rd_data_w[gi]),
        .ram_cenA(cena_w[gi]), .ram_aA(aa_w[gi]),
        .ram_cenB(cenb_w[gi]), .ram_aB(ab_w[gi]), .ram_d(d_w[gi]), .ram_bw(bw_w[gi]),
        .ram_q(q_w[gi])
      );

      // Behavioural dual-port RAM: registered read, optional output register.
      logic [DW-1:0] mem [4096];
      logic [DW-1:0] q_s1 = '0;
      logic [DW-1:0] q_s2 = '0;
      bit            init_done = 1'b0;
      int            coll_cnt = 0;
      exp_t          e;

      assign q_w[gi] = (gi == 1) ? q_s2 : q_s1;

      always @(posedge clk) begin
        if (!init_done) begin
          for (int a = 0; a < 4096; a++) mem[a] = pat(a);
          mem[16'h010] = 8'hA5;
          init_done = 1'b1;
        end else begin
          if (!cenb_w[gi]) mem[ab_w[gi]] <= (mem[ab_w[gi]] & ~bw_w[gi]) | (d_w[gi] & bw_w[gi]);
          if (!cena_w[gi]) q_s1 <= mem[aa_w[gi]];
          q_s2 <= q_s1;
          if (!cena_w[gi] && !cenb_w[gi] && aa_w[gi] == ab_w[gi]) coll_cnt <= coll_cnt + 1;
        end
      end

      always @(negedge clk) begin
        if (exp_q[gi].size() > 0 && exp_q[gi][0].due < cyc) begin
          e = exp_q[gi].pop_front();
          check($sformatf("p%0d_rsp_missing", gi), cyc, e.due);
        end
        if (rd_valid_w[gi]) begin
          if (exp_q[gi].size() == 0) begin
            check($sformatf("p%0d_unexpected_valid", gi), 1, 0);
          end else begin
            e = exp_q[gi].pop_front();
            $display("rsp p%0d cycle=%0d id=%0d data=0x%02h", gi, cyc, rd_id_w[gi], rd_data_w[gi]);
            check($sformatf("p%0d_rsp_id", gi), rd_id_w[gi], e.id);
            check($sformatf("p%0d_rsp_data", gi), rd_data_w[gi], e.data);
            check($sformatf("p%0d_rsp_cycle", gi), cyc, e.due);
          end
        end else begin
          check($sformatf("p%0d_idle_data", gi), rd_data_w[gi], 0);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_req[i] = 1'b1;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] data);
    exp_q[0].push_back('{id: IW'(id), data: data, due: cyc + 1});
    exp_q[1].push_back('{id: IW'(id), data: data, due: cyc + 2});
    $display("req cycle=%0d rd id=%0d expect=0x%02h", cyc, id, data);
  endtask

  task automatic chk_grants(input string tag, input logic [NR-1:0] rg, input logic [NR-1:0] wg);
    for (int p = 0; p < 2; p++) begin
      check({tag, "_rd_gnt"}, rd_gnt_w[p], rg);
      check({tag, "_wr_gnt"}, wr_gnt_w[p], wg);
      check({tag, "_cenA"}, cena_w[p], (rg == '0));
      check({tag, "_cenB"}, cenb_w[p], (wg == '0));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (n) next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int a = 0; a < 4096; a++) ref_mem[a] = pat(a);
    ref_mem[12'h010] = 8'hA5;
    rst = 1'b1;
    clear_reqs();
    repeat (2) next_cycle();

    // Requests present while reset is held: everything must stay quiet.
    for (int i = 0; i < NR; i++) begin
      set_rd(i, AW'(12'h700 + i));
      set_wr(i, AW'(12'h780 + i), DW'(i));
    end
    @(negedge clk);
    chk_grants("in_reset", 4'b0000, 4'b0000);
    for (int p = 0; p < 2; p++) begin
      check("in_reset_valid", rd_valid_w[p], 0);
      check("in_reset_id", rd_id_w[p], 0);
    end
    next_cycle();
    rst = 1'b0;
    clear_reqs();

    // Idle after reset.
    @(negedge clk);
    chk_grants("idle", 4'b0000, 4'b0000);
    for (int p = 0; p < 2; p++) begin
      check("idle_aA", aa_w[p], 0);
      check("idle_aB", ab_w[p], 0);
      check("idle_d", d_w[p], 0);
      check("idle_bw", bw_w[p], 8'hFF);
    end
    next_cycle();

    // Single read: requester 2 reads 0x010 (preloaded 0xA5).
    set_rd(2, 12'h010);
    @(negedge clk);
    chk_grants("single", 4'b0100, 4'b0000);
    for (int p = 0; p < 2; p++) check("single_aA", aa_w[p], 12'h010);
    push_exp(2, 8'hA5);
    next_cycle();
    clear_reqs();
    repeat (3) next_cycle();

    // Round-robin from reset with all read requests held.
    for (int i = 0; i < NR; i++) set_rd(i, AW'(12'h100 + i));
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_grants("rr", NR'(1 << (k % NR)), 4'b0000);
      push_exp(k % NR, ref_mem[12'h100 + (k % NR)]);
      next_cycle();
    end
    clear_reqs();
    repeat (3) next_cycle();

    // Collision: write 0x5C to 0x020 (req 1) while reading 0x020 (req 3).
    set_wr(1, 12'h020, 8'h5C);
    set_rd(3, 12'h020);
    @(negedge clk);
    chk_grants("collide", 4'b0000, 4'b0010);
    for (int p = 0; p < 2; p++) begin
      check("collide_aB", ab_w[p], 12'h020);
      check("collide_d", d_w[p], 8'h5C);
    end
    ref_mem[12'h020] = 8'h5C;
    next_cycle();
    wr_req = '0;
    @(negedge clk);
    chk_grants("retry", 4'b1000, 4'b0000);
    for (int p = 0; p < 2; p++) check("retry_aA", aa_w[p], 12'h020);
    push_exp(3, ref_mem[12'h020]);
    next_cycle();
    clear_reqs();

    // Concurrent distinct addresses.
    set_wr(0, 12'h030, 8'h77);
    set_rd(1, 12'h031);
    @(negedge clk);
    chk_grants("concurrent", 4'b0010, 4'b0001);
    push_exp(1, ref_mem[12'h031]);
    ref_mem[12'h030] = 8'h77;
    next_cycle();
    clear_reqs();

    // Full throughput: wr_ptr=1, rd_ptr=2 at this point.
    for (int i = 0; i < NR; i++) begin
      set_rd(i, AW'(12'h300 + i));
      set_wr(i, AW'(12'h200 + i), DW'(8'hC0 + i));
    end
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      chk_grants("both", NR'(1 << ((2 + k) % NR)), NR'(1 << ((1 + k) % NR)));
      push_exp((2 + k) % NR, ref_mem[12'h300 + ((2 + k) % NR)]);
      ref_mem[12'h200 + ((1 + k) % NR)] = DW'(8'hC0 + ((1 + k) % NR));
      next_cycle();
    end
    clear_reqs();

    // Read back written words through requester 0.
    for (int j = 0; j < 5; j++) begin
      logic [AW-1:0] a;
      a = (j < 4) ? AW'(12'h200 + j) : 12'h030;
      rd_req = '0;
      set_rd(0, a);
      @(negedge clk);
      chk_grants("readback", 4'b0001, 4'b0000);
      push_exp(0, ref_mem[a]);
      next_cycle();
    end
    clear_reqs();
    repeat (3) next_cycle();

    // Reset one cycle after a read grant: the response must never appear.
    set_rd(0, 12'h010);
    @(negedge clk);
    chk_grants("pre_rst", 4'b0001, 4'b0000);
    next_cycle();
    clear_reqs();
    do_reset(2);
    repeat (2) next_cycle();

    // After reset both pointers start at 0.
    for (int i = 0; i < NR; i++) begin
      set_rd(i, AW'(12'h400 + i));
      set_wr(i, AW'(12'h500 + i), DW'(8'h90 + i));
    end
    @(negedge clk);
    chk_grants("post_rst", 4'b0001, 4'b0001);
    push_exp(0, ref_mem[12'h400]);
    ref_mem[12'h500] = 8'h90;
    next_cycle();
    clear_reqs();
    repeat (4) next_cycle();

    @(negedge clk);
    check("drain_p0", exp_q[0].size(), 0);
    check("drain_p1", exp_q[1].size(), 0);
    check("ram_collision_p0", g_dut[0].coll_cnt, 0);
    check("ram_collision_p1", g_dut[1].coll_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
